// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port round-robin arbiter and access sequencer for the
// single-port data memory. Serialises one access at a time through
// IDLE -> ISSUE -> (WAIT) -> RESP and returns load data after LAT cycles.
module dm_arbiter #(
   parameter int unsigned AW  = 32,
   parameter int unsigned DW  = 32,
   parameter int unsigned LAT = 0
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_adr,
   input  logic [DW-1:0] m0_wdata,
   output logic          m0_gnt,
   output logic          m0_rvalid,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_adr,
   input  logic [DW-1:0] m1_wdata,
   output logic          m1_gnt,
   output logic          m1_rvalid,
   output logic [DW-1:0] m1_rdata,
   output logic          dm_we,
   output logic [AW-1:0] dm_adr,
   output logic [DW-1:0] dm_wdata,
   input  logic [DW-1:0] dm_rdata
);

   localparam int unsigned CW = 2;
   localparam logic [CW-1:0] LAT_M1 = CW'((LAT > 0) ? LAT - 1 : 0);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t        state;
   logic          rr_ptr;
   logic          owner;
   logic          req_we;
   logic [CW-1:0] cnt;
   logic          sel_c;

   // winner: the sole requester, or the port the pointer favours on a tie
   assign sel_c = m1_req & (~m0_req | rr_ptr);

   // sequencer: state, arbitration pointer and all registered outputs
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         rr_ptr    <= 1'b0;
         owner     <= 1'b0;
         req_we    <= 1'b0;
         cnt       <= '0;
         m0_gnt    <= 1'b0;
         m1_gnt    <= 1'b0;
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
         dm_we     <= 1'b0;
         dm_adr    <= '0;
         dm_wdata  <= '0;
      end else begin
         m0_gnt    <= 1'b0;
         m1_gnt    <= 1'b0;
         m0_rvalid <= 1'b0;
         m1_rvalid <= 1'b0;
         dm_we     <= 1'b0;
         dm_wdata  <= '0;
         case (state)
            IDLE: begin
               if (m0_req | m1_req) begin
                  owner    <= sel_c;
                  rr_ptr   <= ~sel_c;
                  req_we   <= sel_c ? m1_we : m0_we;
                  dm_we    <= sel_c ? m1_we : m0_we;
                  dm_adr   <= sel_c ? m1_adr : m0_adr;
                  dm_wdata <= sel_c ? m1_wdata : m0_wdata;
                  m0_gnt   <= ~sel_c;
                  m1_gnt   <= sel_c;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               if (req_we) begin
                  dm_adr <= '0;
                  state  <= IDLE;
               end else if (LAT == 0) begin
                  dm_adr <= '0;
                  state  <= RESP;
                  if (owner) begin
                     m1_rvalid <= 1'b1;
                     m1_rdata  <= dm_rdata;
                  end else begin
                     m0_rvalid <= 1'b1;
                     m0_rdata  <= dm_rdata;
                  end
               end else begin
                  cnt   <= LAT_M1;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  dm_adr <= '0;
                  state  <= RESP;
                  if (owner) begin
                     m1_rvalid <= 1'b1;
                     m1_rdata  <= dm_rdata;
                  end else begin
                     m0_rvalid <= 1'b1;
                     m0_rdata  <= dm_rdata;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and access sequencer for the single-port data memory (DM). It shares DM between the processor's memory-access stage (port 0) and a second requester such as a loader or debug master (port 1). It serialises requests with round-robin priority, drives the DM write enable, address and write data for exactly one cycle per access, and returns read data after a parameterised memory latency. It sits between the MA-stage memory interface and the DM instance.

## Interface
- AW, 32, address width
- DW, 32, data width
- LAT, 0, DM read latency in cycles after the issue cycle (legal range 0..3)

- CLK  in  1  single clock; all state updates on the rising edge
- RST  in  1  asynchronous, active-low reset
- m0_req / m1_req  in  1  access request; held until the matching gnt
- m0_we / m1_we  in  1  1 = store, 0 = load; stable while req is high
- m0_adr / m1_adr  in  AW  byte address; stable while req is high
- m0_wdata / m1_wdata  in  DW  store data; stable while req is high
- m0_gnt / m1_gnt  out  1  one-cycle pulse marking the issue cycle of that port's access
- m0_rvalid / m1_rvalid  out  1  one-cycle pulse; load data valid
- m0_rdata / m1_rdata  out  DW  load data; holds its last value between rvalids
- dm_we  out  1  DM write enable
- dm_adr  out  AW  DM address
- dm_wdata  out  DW  DM write data
- dm_rdata  in  DW  DM read data, valid LAT cycles after the issue cycle

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If no req is high, stay in IDLE.
  - Otherwise select one port and register its we/adr/wdata into internal request registers. Next state is ISSUE.
- **Selection**
  - If only one req is high, that port wins.
  - If both are high, the port named by the round-robin pointer wins.
  - The pointer flips to the other port on every grant.
  - After reset the pointer favours port 0.
- **ISSUE** (exactly one cycle)
  - dm_adr and dm_wdata come from the request registers.
  - dm_we = registered we.
  - gnt of the selected port = 1.
  - Store: next state is IDLE. No rvalid is produced for stores.
  - Load with LAT=0: sample dm_rdata at the end of ISSUE, then go to RESP.
  - Load with LAT>0: load a counter with LAT-1, then go to WAIT.
- **WAIT**
  - dm_adr is held at the issued address; dm_we = 0.
  - The counter decrements each cycle.
  - When the counter is 0, sample dm_rdata at the end of that cycle, then go to RESP.
- **RESP** (one cycle)
  - rvalid of the owning port = 1, and that port's rdata is updated with the sampled value.
  - Next state is IDLE.
- Outside ISSUE: dm_we = 0, dm_wdata = 0. dm_adr = 0 in IDLE and RESP.
- Requester rules:
  - The requester keeps req, we, adr and wdata stable from assertion until gnt.
  - It drops req in the cycle after gnt.
  - A req still high in the cycle after gnt counts as a new request.
- A port may request again while its own load is still pending. The new request is only considered in IDLE, so responses stay in order.
- The port that was not selected keeps waiting. With both ports requesting continuously, grants alternate strictly, so neither port waits more than one other access.

## Timing
- Reset (RST low, asynchronous assertion):
  - State = IDLE, pointer = port 0.
  - All gnt and rvalid = 0, all rdata = 0.
  - dm_we = 0, dm_adr = 0, dm_wdata = 0.
- Reset mid-access: a pending load is discarded and no rvalid is ever produced for it. A store already issued stays issued (its ISSUE cycle has passed). A store not yet issued is lost.
- Store latency: req seen in cycle N → gnt and dm_we in cycle N+1 → IDLE in N+2. A store occupies the arbiter for 2 cycles.
- Load latency: req seen in cycle N → gnt in N+1 → dm_rdata sampled at end of N+1+LAT → rvalid in N+2+LAT → IDLE in N+3+LAT.
- gnt and rvalid are registered-state decodes and never high at the same time for the same access.
- All outputs are glitch-free decodes of registered state.

## Test plan
- **Single store:** m0 store adr=0x10, wdata=0xDEADBEEF, request seen in cycle 0.
  - Cycle 1: m0_gnt=1, dm_we=1, dm_adr=0x10, dm_wdata=0xDEADBEEF.
  - No m0_rvalid. IDLE in cycle 2.
- **Load, LAT=2:** m1 load adr=0x20, DM model returns 0x12345678 two cycles after issue.
  - m1_gnt in cycle 1, m1_rvalid in cycle 4 with m1_rdata=0x12345678.
  - m1_rdata holds that value afterwards.
- **Load, LAT=0:** same load as above.
  - gnt in cycle 1, rvalid in cycle 2 with the correct data.
- **Contention:** both ports assert a store every time they become free, for 8 accesses.
  - Grants go m0, m1, m0, m1, …
  - Each dm_adr and dm_wdata matches the granted port.
- **Reset mid-load:** with LAT=3, pull RST low during WAIT.
  - All outputs are 0 immediately.
  - No rvalid after release.
  - Next request from m1 is granted normally, and the pointer prefers m0 on the first tie.
- **Back-to-back same port:** m0 issues load adr=0x4, then a store with req held through the response.
  - The store gnt occurs only after m0_rvalid, in the cycle following IDLE.
  - dm_we never overlaps WAIT.
